bit_compare: RTL and testbench

- Registered magnitude/equality comparator for two WIDTH-bit operands A and B.
- Produces four one-hot-style flags: greater, equal, less and not-equal.
- Also keeps a saturating count of enabled cycles where the operands differ.
- Sits as a leaf utility in datapath/control logic. Default WIDTH=1 gives the classic 1-bit comparator.

---
 rtl/bit_compare.sv | 83 ++++++++
 tb/tb_bit_compare.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bit_compare.sv
// Registered WIDTH-bit comparator with greater/equal/less/not-equal flags and a
// saturating mismatch counter. Define BITCOMPARE_SIGNED_EN for signed C/E flags.
module bit_compare #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             C,
    output logic             D,
    output logic             E,
    output logic             F,
    output logic             VLD,
    output logic [CNT_W-1:0] NE_CNT
);

    logic gt, lt, eq;

`ifdef BITCOMPARE_SIGNED_EN
    // With WIDTH=1 the single bit is the sign, so 1 reads as -1.
    assign gt = $signed(A) > $signed(B);
    assign lt = $signed(A) < $signed(B);
`else
    assign gt = A > B;
    assign lt = A < B;
`endif
    assign eq = (A == B);

    logic             c_q, d_q, e_q, f_q, vld_q;
    logic             c_d, d_d, e_d, f_d, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_full;

    assign cnt_full = (cnt_q == {CNT_W{1'b1}});

    always_comb begin
        c_d   = c_q;
        d_d   = d_q;
        e_d   = e_q;
        f_d   = f_q;
        vld_d = vld_q;
        cnt_d = cnt_q;
        if (EN) begin
            c_d   = gt;
            d_d   = eq;
            e_d   = lt;
            f_d   = ~eq;
            vld_d = 1'b1;
            // Saturate rather than wrap so a long mismatch run never reads as few.
            if (!eq && !cnt_full)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q   <= 1'b0;
            d_q   <= 1'b0;
            e_q   <= 1'b0;
            f_q   <= 1'b0;
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            c_q   <= c_d;
            d_q   <= d_d;
            e_q   <= e_d;
            f_q   <= f_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign C      = c_q;
    assign D      = d_q;
    assign E      = e_q;
    assign F      = f_q;
    assign VLD    = vld_q;
    assign NE_CNT = cnt_q;

endmodule

// File: tb/tb_bit_compare.sv
// Randomised self-checking bench for bit_compare: a 1-bit/2-bit-counter instance
// and an 8-bit instance, both checked against an arithmetic reference model.
module tb_bit_compare;

`ifdef BITCOMPARE_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 1: WIDTH=1, CNT_W=2
    logic       en1, a1, b1, c1, d1, e1, f1, v1;
    logic [1:0] cnt1;
    // Instance 8: WIDTH=8, CNT_W=8
    logic       en8, c8, d8, e8, f8, v8;
    logic [7:0] a8, b8, cnt8;

    bit_compare #(.WIDTH(1), .CNT_W(2)) u_w1 (
        .clk(clk), .rst_n(rst_n), .EN(en1), .A(a1), .B(b1),
        .C(c1), .D(d1), .E(e1), .F(f1), .VLD(v1), .NE_CNT(cnt1));

    bit_compare #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .EN(en8), .A(a8), .B(b8),
        .C(c8), .D(d8), .E(e8), .F(f8), .VLD(v8), .NE_CNT(cnt8));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: flags {C,D,E,F}, valid, mismatch count
    logic [3:0] m1_f, m8_f;
    logic       m1_v, m8_v;
    int         m1_cnt, m8_cnt;

    function automatic longint as_num(input longint v, input int w);
        if (SGN && v[w-1]) return v - (longint'(1) << w);
        return v;
    endfunction

    function automatic logic [3:0] ref_flags(input longint a, input longint b);
        return {a > b, a == b, a < b, a != b};
    endfunction

    task automatic model_reset();
        m1_f = '0; m1_v = 0; m1_cnt = 0;
        m8_f = '0; m8_v = 0; m8_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".w1.C"},   c1,   m1_f[3]);
        chk({tag, ".w1.D"},   d1,   m1_f[2]);
        chk({tag, ".w1.E"},   e1,   m1_f[1]);
        chk({tag, ".w1.F"},   f1,   m1_f[0]);
        chk({tag, ".w1.VLD"}, v1,   m1_v);
        chk({tag, ".w1.CNT"}, cnt1, m1_cnt);
        chk({tag, ".w8.C"},   c8,   m8_f[3]);
        chk({tag, ".w8.D"},   d8,   m8_f[2]);
        chk({tag, ".w8.E"},   e8,   m8_f[1]);
        chk({tag, ".w8.F"},   f8,   m8_f[0]);
        chk({tag, ".w8.VLD"}, v8,   m8_v);
        chk({tag, ".w8.CNT"}, cnt8, m8_cnt);
    endtask

    // One rising edge: update the model from the inputs held across it, then check.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            if (en1) begin
                m1_f = ref_flags(as_num(a1, 1), as_num(b1, 1));
                m1_v = 1;
                if (a1 != b1 && m1_cnt < 3) m1_cnt++;
            end
            if (en8) begin
                m8_f = ref_flags(as_num(a8, 8), as_num(b8, 8));
                m8_v = 1;
                if (a8 != b8 && m8_cnt < 255) m8_cnt++;
            end
        end
        #1;
        check_all(tag);
    endtask

    int saved;

    initial begin
        rst_n = 0;
        en1 = 1; a1 = 1; b1 = 0;
        en8 = 1; a8 = 8'h01; b8 = 8'h00;
        model_reset();
        #1;
        check_all("rst0");
        repeat (3) tick("rst_hold");
        rst_n = 1;

        // 1-bit exhaustive sequence 00,10,01,11
        en8 = 0;
        for (int i = 0; i < 4; i++) begin
            a1 = i[0]; b1 = i[1];
            tick($sformatf("exh%0d", i));
        end
        chk("exh.VLD", v1, 1);
        chk("exh.CNT", cnt1, 2);

        // Hold with EN low
        a1 = 1; b1 = 0;
        tick("hold_load");
        saved = cnt1;
        en1 = 0; a1 = 0; b1 = 1;
        en8 = 0; a8 = 8'hFF; b8 = 8'h00;
        repeat (5) tick("hold");
        chk("hold.C", c1, SGN ? 0 : 1);
        chk("hold.E", e1, SGN ? 1 : 0);
        chk("hold.F", f1, 1);
        chk("hold.CNT", cnt1, saved);

        // Asynchronous reset mid-cycle, away from any edge
        #3; rst_n = 0; #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk); rst_n = 1;

        // Saturation on the 2-bit counter
        en1 = 1; a1 = 1; b1 = 0;
        for (int i = 1; i <= 6; i++) begin
            tick($sformatf("sat%0d", i));
            chk($sformatf("sat%0d.CNT", i), cnt1, (i < 3) ? i : 3);
        end

        // Multi-bit
        en1 = 0; en8 = 1;
        a8 = 8'h80; b8 = 8'h7F;
        tick("mb_80_7f");
        chk("mb_80_7f.C", c8, SGN ? 0 : 1);
        chk("mb_80_7f.E", e8, SGN ? 1 : 0);
        a8 = 8'hA5; b8 = 8'hA5;
        tick("mb_a5");
        chk("mb_a5.D", d8, 1);
        chk("mb_a5.F", f8, 0);

        // Random traffic with invariants
        for (int i = 0; i < 1000; i++) begin
            en1 = ($urandom_range(7) != 0);
            en8 = ($urandom_range(7) != 0);
            a1 = $urandom_range(1); b1 = $urandom_range(1);
            a8 = 8'($urandom); b8 = ($urandom_range(3) == 0) ? a8 : 8'($urandom);
            tick("rnd");
            if (m8_v) begin
                chk("rnd.w8.onehot", c8 + d8 + e8, 1);
                chk("rnd.w8.F_CE", f8, c8 | e8);
            end
            if (m1_v) begin
                chk("rnd.w1.onehot", c1 + d1 + e1, 1);
                chk("rnd.w1.F_CE", f1, c1 | e1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
